// File: rtl/led_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : led_counter_pkg
//  Purpose   : Shared mode codes, FSM state type and a mode normaliser for the
//              LED range counter.
//  Revision  : 1.0 - initial release
// ============================================================================
package led_counter_pkg;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_WRAP    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The reserved encoding 2'b11 behaves as one-shot; folding it here keeps
    // the datapath decode down to three cases.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_ONESHOT : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module    : led_tick_gen
//  Purpose   : Prescaler producing one tick every PRESCALE enabled cycles.
//  Ports     : clk    - rising-edge clock
//              rst_n  - asynchronous active-low reset
//              clear  - synchronous clear of the phase (wins over enable)
//              enable - advance the phase this cycle
//              tick   - high in the enabled cycle that completes a period
//  Revision  : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // The phase is simply held while disabled, so a pause resumes mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    assign tick = enable && !clear && (phase == LAST);

endmodule
`default_nettype wire

// File: rtl/led_range_counter.sv
`default_nettype none
// ============================================================================
//  Module    : led_range_counter
//  Purpose   : Steps a count from a captured start value toward a captured end
//              value, one LSB per prescaler tick, in one-shot, wrap or bounce
//              mode, flagging arrival at the end value.
//  Ports     : clk       - rising-edge clock
//              rst_n     - asynchronous active-low reset
//              start     - single-cycle run request (captures inputs)
//              start_num - first value of the sequence
//              end_num   - target value
//              mode      - 00 one-shot, 01 wrap, 10 bounce, 11 one-shot
//              pause     - level, freezes count and prescaler
//              count     - current value
//              busy      - run in progress
//              done      - one-cycle pulse on each arrival at the end value
//              at_end    - count equals the captured end value
//  Revision  : 1.0 - initial release
// ============================================================================
module led_range_counter
    import led_counter_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_num,
    input  logic [WIDTH-1:0] end_num,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             at_end
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] start_r, start_nx;
    logic [WIDTH-1:0] end_r, end_nx;
    logic [1:0]       mode_r, mode_nx;
    logic             heading_end, heading_nx;   // 1: moving toward end_r
    logic [WIDTH-1:0] count_nx;
    logic             busy_nx, done_nx, at_end_nx;

    logic             tick;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] step_val;

    led_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .enable ((state == ST_RUN) && !pause),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            start_r     <= '0;
            end_r       <= '0;
            mode_r      <= MODE_ONESHOT;
            heading_end <= 1'b1;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            at_end      <= 1'b0;
        end else begin
            state       <= state_nx;
            start_r     <= start_nx;
            end_r       <= end_nx;
            mode_r      <= mode_nx;
            heading_end <= heading_nx;
            count       <= count_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            at_end      <= at_end_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        start_nx   = start_r;
        end_nx     = end_r;
        mode_nx    = mode_r;
        heading_nx = heading_end;
        count_nx   = count;
        done_nx    = 1'b0;
        at_end_nx  = at_end;

        target = heading_end ? end_r : start_r;

        // Only wrap mode can sit in RUN on end_r while heading toward it; the
        // next tick there restarts the sequence instead of stepping.
        if (heading_end && (count == end_r)) begin
            step_val = start_r;
        end else if (target > count) begin
            step_val = count + WIDTH'(1);
        end else begin
            step_val = count - WIDTH'(1);
        end

        if (start) begin
            start_nx   = start_num;
            end_nx     = end_num;
            mode_nx    = norm_mode(mode);
            heading_nx = 1'b1;
            count_nx   = start_num;
            if (start_num == end_num) begin
                // Degenerate run: already at the end, finish in the load cycle.
                state_nx  = ST_IDLE;
                done_nx   = 1'b1;
                at_end_nx = 1'b1;
            end else begin
                state_nx  = ST_RUN;
                at_end_nx = 1'b0;
            end
        end else if ((state == ST_RUN) && tick) begin
            count_nx  = step_val;
            at_end_nx = (step_val == end_r);
            if (heading_end && (step_val == end_r)) begin
                done_nx = 1'b1;
                case (mode_r)
                    MODE_BOUNCE: heading_nx = 1'b0;
                    MODE_WRAP:   ;
                    default:     state_nx = ST_IDLE;
                endcase
            end
            if (!heading_end && (step_val == start_r)) begin
                heading_nx = 1'b1;
            end
        end

        busy_nx = (state_nx == ST_RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_led_range_counter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_led_range_counter
//  Purpose   : Self-checking bench for led_range_counter. Two instances
//              (PRESCALE 1 and 4) share stimulus; a sequence-position model
//              predicts every output each cycle.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_led_range_counter;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] start_num = '0;
    logic [WIDTH-1:0] end_num = '0;
    logic [1:0]       mode = 2'b00;
    logic             pause = 1'b0;

    logic [WIDTH-1:0] count_a, count_b;
    logic             busy_a, busy_b, done_a, done_b, at_end_a, at_end_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    led_range_counter #(.WIDTH(WIDTH), .PRESCALE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .start_num(start_num),
        .end_num(end_num), .mode(mode), .pause(pause),
        .count(count_a), .busy(busy_a), .done(done_a), .at_end(at_end_a)
    );

    led_range_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .start_num(start_num),
        .end_num(end_num), .mode(mode), .pause(pause),
        .count(count_b), .busy(busy_b), .done(done_b), .at_end(at_end_b)
    );

    // ---------------- reference model ----------------
    // A run is a position index into the ideal value sequence; the value is
    // derived from the position with plain arithmetic per mode.
    int m_s[2], m_e[2], m_mode[2], m_pos[2], m_phase[2], m_count[2];
    bit m_run[2], m_done[2], m_at_end[2];

    function automatic int ps(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s[k] = 0; m_e[k] = 0; m_mode[k] = 0; m_pos[k] = 0;
            m_phase[k] = 0; m_count[k] = 0; m_run[k] = 0;
            m_done[k] = 0; m_at_end[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        int len, dir, p, off;
        if (start) begin
            m_s[k]      = int'(start_num);
            m_e[k]      = int'(end_num);
            m_mode[k]   = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
            m_pos[k]    = 0;
            m_phase[k]  = 0;
            m_count[k]  = m_s[k];
            m_run[k]    = (m_s[k] != m_e[k]);
            m_done[k]   = (m_s[k] == m_e[k]);
            m_at_end[k] = (m_s[k] == m_e[k]);
        end else begin
            m_done[k] = 0;
            if (m_run[k] && !pause) begin
                m_phase[k]++;
                if (m_phase[k] == ps(k)) begin
                    m_phase[k] = 0;
                    m_pos[k]++;
                    len = (m_e[k] > m_s[k]) ? m_e[k] - m_s[k] : m_s[k] - m_e[k];
                    dir = (m_e[k] > m_s[k]) ? 1 : -1;
                    if (m_mode[k] == 1) begin
                        off = m_pos[k] % (len + 1);
                    end else if (m_mode[k] == 2) begin
                        p   = m_pos[k] % (2 * len);
                        off = (p <= len) ? p : 2 * len - p;
                    end else begin
                        off = m_pos[k];
                    end
                    m_count[k]  = m_s[k] + dir * off;
                    m_at_end[k] = (off == len);
                    m_done[k]   = (off == len);
                    if (m_mode[k] == 0 && off == len) m_run[k] = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_edge(0);
                model_edge(1);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("a.count",  int'(count_a),  m_count[0]);
            chk("a.busy",   int'(busy_a),   int'(m_run[0]));
            chk("a.done",   int'(done_a),   int'(m_done[0]));
            chk("a.at_end", int'(at_end_a), int'(m_at_end[0]));
            chk("b.count",  int'(count_b),  m_count[1]);
            chk("b.busy",   int'(busy_b),   int'(m_run[1]));
            chk("b.done",   int'(done_b),   int'(m_done[1]));
            chk("b.at_end", int'(at_end_b), int'(m_at_end[1]));
        end
    end

    // Called just after a falling edge; returns after the falling edge that
    // follows the load edge.
    task automatic do_start(input int s, input int e, input int m);
        start     = 1'b1;
        start_num = WIDTH'(s);
        end_num   = WIDTH'(e);
        mode      = 2'(m);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // ---------------- stimulus with literal expectations ----------------
    initial begin
        int bseq[8];
        int t;
        bseq = '{2, 3, 4, 5, 4, 3, 2, 3};

        repeat (2) @(negedge clk);
        chk("rst.count", int'(count_a), 0);
        chk("rst.busy",  int'(busy_a), 0);
        chk("rst.done",  int'(done_a), 0);
        chk("rst.at_end", int'(at_end_b), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // One-shot up 3..7, one step per cycle on the PRESCALE=1 instance
        do_start(3, 7, 0);
        chk("up.load", int'(count_a), 3);
        chk("up.busy", int'(busy_a), 1);
        for (int i = 4; i <= 7; i++) begin
            @(negedge clk);
            chk("up.count", int'(count_a), i);
        end
        chk("up.done", int'(done_a), 1);
        chk("up.at_end", int'(at_end_a), 1);
        chk("up.busy_end", int'(busy_a), 0);
        @(negedge clk);
        chk("up.hold", int'(count_a), 7);
        chk("up.done_clr", int'(done_a), 0);

        // One-shot down 20..17 on the PRESCALE=4 instance
        do_start(20, 17, 0);
        chk("dn.load", int'(count_b), 20);
        repeat (4) @(negedge clk);
        chk("dn.first_step", int'(count_b), 19);
        repeat (8) @(negedge clk);
        chk("dn.end", int'(count_b), 17);
        chk("dn.done", int'(done_b), 1);
        chk("dn.busy", int'(busy_b), 0);

        // Wrap 30/31
        do_start(30, 31, 1);
        chk("wr.load", int'(count_a), 30);
        @(negedge clk);
        chk("wr.31", int'(count_a), 31);
        chk("wr.done", int'(done_a), 1);
        @(negedge clk);
        chk("wr.30", int'(count_a), 30);
        @(negedge clk);
        chk("wr.31b", int'(count_a), 31);
        chk("wr.busy", int'(busy_a), 1);

        // Bounce 2..5
        do_start(2, 5, 2);
        chk("bo.load", int'(count_a), bseq[0]);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("bo.count", int'(count_a), bseq[i]);
            chk("bo.done", int'(done_a), int'(bseq[i] == 5));
            chk("bo.at_end", int'(at_end_a), int'(bseq[i] == 5));
        end

        // Restart mid-run
        do_start(0, 9, 0);
        repeat (4) @(negedge clk);
        chk("rs.mid", int'(count_a), 4);
        do_start(10, 12, 0);
        chk("rs.reload", int'(count_a), 10);
        chk("rs.nodone", int'(done_a), 0);

        // Pause keeps prescale phase
        do_start(0, 9, 0);
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        chk("pa.b_hold", int'(count_b), 0);
        chk("pa.a_resume", int'(count_a), 3);
        @(negedge clk);
        chk("pa.b_step", int'(count_b), 1);
        chk("pa.a_step", int'(count_a), 4);

        // start == end
        do_start(9, 9, 1);
        chk("eq.count", int'(count_a), 9);
        chk("eq.done", int'(done_a), 1);
        chk("eq.at_end", int'(at_end_b), 1);
        chk("eq.busy", int'(busy_a), 0);
        @(negedge clk);
        chk("eq.done_clr", int'(done_a), 0);
        chk("eq.at_end_hold", int'(at_end_a), 1);

        // Asynchronous reset mid-run
        do_start(0, 31, 2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.count", int'(count_a), 0);
        chk("ar.busy", int'(busy_b), 0);
        chk("ar.at_end", int'(at_end_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            start = ($urandom_range(0, 11) == 0);
            if (start) begin
                start_num = WIDTH'($urandom_range(0, 31));
                case ($urandom_range(0, 3))
                    0: end_num = start_num;
                    1: end_num = WIDTH'($urandom_range(0, 31));
                    default: begin
                        t = int'(start_num) + ($urandom_range(0, 1) ? 1 : -1)
                            * int'($urandom_range(1, 4));
                        if (t < 0) t = 0;
                        if (t > 31) t = 31;
                        end_num = WIDTH'(t);
                    end
                endcase
                mode = 2'($urandom_range(0, 3));
            end
            pause = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        pause = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_range_counter.md
# led_range_counter

Parametrised LED sequence counter: on a start pulse it loads a start value and steps one LSB at a time toward an end value, with an up or down direction derived automatically. It runs in one-shot, wrap or bounce mode, and a built-in prescaler slows the step rate to something visible. It sits between the board-control logic (buttons/switch decoder) and the LED/7-segment drivers, and flags arrival at the end value.

## Interface
- WIDTH, 5, bit width of start_num, end_num and count (≥1)
- PRESCALE, 1, clock cycles per count step (≥1); prescaler width = max(1, clog2(PRESCALE))
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  single-cycle request; captures start_num/end_num/mode and begins a run
- start_num  in  WIDTH  first value of the sequence (unsigned)
- end_num  in  WIDTH  target value (unsigned)
- mode  in  2  00 one-shot, 01 wrap, 10 bounce, 11 treated as one-shot
- pause  in  1  level; freezes prescaler and count while high
- count  out  WIDTH  current value
- busy  out  1  high while a run is active
- done  out  1  one-cycle pulse on each arrival at end_num
- at_end  out  1  level; high while a run's count equals its captured end_num

## Operation
- Capture registers: start_r, end_r, mode_r are loaded only on start. Input changes mid-run are ignored.
- Direction: up if end_r > start_r; down if end_r < start_r. In bounce mode the direction flips at each endpoint.
- FSM states:
  - IDLE: count holds its value; start → LOAD behaviour (next cycle count = start_num, busy = 1, state RUN).
  - RUN: on each tick, count moves one step toward the current target.
  - Endpoint handling when count reaches the target:
    - one-shot: done pulses, busy drops, return to IDLE with count = end_r.
    - wrap: done pulses, then on the next tick count = start_r; remain in RUN.
    - bounce: target alternates end_r / start_r. done pulses only on arrival at end_r, never at start_r.
- start_num == end_num: count loads, done and at_end assert in the load cycle. Treated as one-shot in every mode; busy stays 0.
- start while busy: restart. Registers are recaptured, count reloads, prescaler clears, no done for the aborted run.
- Priority: rst_n > start > pause > tick.
- at_end asserts in the same cycle count becomes end_r. It clears when count leaves end_r or on start with start_num ≠ end_num.
- No arithmetic overflow is possible: count always stays within [min(start_r,end_r), max(start_r,end_r)].

## Timing
- Reset values:
  - count = 0, busy = 0, done = 0, at_end = 0
  - state IDLE, prescaler = 0, captured registers = 0
- Reset is honoured mid-run immediately (asynchronous), with no pending done.
- Load latency: start sampled at edge N → count = start_num, busy = 1 after edge N.
- Prescaler:
  - It counts 0..PRESCALE-1 while RUN and !pause, and clears on start.
  - A tick occurs when it equals PRESCALE-1; the first step happens PRESCALE cycles after load.
  - With PRESCALE = 1, count steps every cycle.
- All outputs are registered. done and at_end update on the same edge as the count value they describe.
- Pause: the count freezes on the edge where pause is sampled high, and the prescaler phase is retained. Deasserting pause resumes without losing partial prescale.

## Structure
- Package led_counter_pkg holds:
  - mode localparams MODE_ONESHOT / MODE_WRAP / MODE_BOUNCE
  - FSM state encoding (IDLE, RUN)
- Sub-module led_tick_gen (PRESCALE parameter; clk, rst_n, clear, enable in; tick out) holds the prescaler. The top holds the FSM, capture registers and count datapath.

## Test plan
- WIDTH=5, PRESCALE=1, one-shot, start 3 end 7 → count 3,4,5,6,7 on successive cycles; done + at_end with 7; busy 0 after; count holds 7.
- One-shot down, start 20 end 17, PRESCALE=4 → steps every 4 cycles 20→17; single done; busy clears on arrival.
- Wrap, start 30 end 31, PRESCALE=1 → sequence 30,31,30,31…; done on every 31; busy stays 1.
- Bounce, start 2 end 5 → 2,3,4,5,4,3,2,3…; done only at 5; at_end only while count=5.
- Restart and pause:
  - Start mid-run (during 0→9, at count 4, start_num 10 end 12) → next cycle count 10, no done for the old run.
  - pause for 3 cycles → count frozen, resumes with the same prescale phase.
- Edge cases:
  - start_num == end_num == 9 → count 9, done and at_end in the load cycle, busy 0.
  - rst_n low mid-run → all outputs 0 asynchronously.
